memory_cycle: RTL and testbench

//  MEM stage of the 5-stage RV32I pipeline; consumes the EX/MEM register outputs of execute_cycle.
//  - Resolves branches/jumps, raising the flush and PC redirect for fetch/decode/execute.
//  - Performs loads/stores on an internal synchronous data memory.
//  - Holds the MEM/WB pipeline register; load extraction happens after the read register.

---
 rtl/pipeline_pkg.sv | 26 ++
 rtl/memory_dmem.sv | 25 ++
 rtl/memory_cycle.sv | 160 ++++++++++++++++
 tb/tb_memory_cycle.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcodes, access sizes, write-back selects, NOP encoding.
package pipeline_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } size_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_LD  = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

endpackage

// File: rtl/memory_dmem.sv
// Data memory: byte-enable write, registered read-first output.
module memory_dmem #(
  parameter int DMEM_WORDS = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic              i_memory_clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DMEM_WORDS];

  // Write enabled lanes; read returns the pre-write word (read-first).
  always_ff @(posedge i_memory_clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/memory_cycle.sv
// MEM stage: branch resolution, data memory access, MEM/WB pipeline register.
module memory_cycle
  import pipeline_pkg::*;
#(
  parameter int DMEM_WORDS = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic        i_memory_clk,
  input  logic        i_memory_reset,
  input  logic [31:0] i_memory_pc,
  input  logic [31:0] i_memory_inst,
  input  logic        i_memory_insn_vld,
  input  logic        i_memory_ctrl,
  input  logic [31:0] i_memory_alu_data,
  input  logic [31:0] i_memory_rs2_data,
  input  logic        i_memory_br_equal,
  input  logic        i_memory_br_less,
  input  logic        i_memory_lsu_wren,
  input  logic [2:0]  i_memory_slt_sl,
  input  logic [1:0]  i_memory_wb_sel,
  input  logic        i_memory_rd_wren,
  output logic        o_memory_flush,
  output logic [31:0] o_memory_pc_target,
  output logic [31:0] o_memory_fwd_alu_data,
  output logic        o_memory_misaligned,
  output logic [31:0] o_memory_wb_data,
  output logic        o_memory_rd_wren_wb,
  output logic [31:0] o_memory_inst_wb,
  output logic [31:0] o_memory_pc_wb,
  output logic        o_memory_insn_vld_wb,
  output logic        o_memory_ctrl_wb
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        taken;
  logic        is_half, is_word, is_access, mis_now;
  logic        store_we;
  logic [3:0]  be;
  logic [31:0] wdata, rdata;
  logic [31:0] alu_q;
  logic [2:0]  slt_q;
  logic [1:0]  wb_sel_q;
  logic [31:0] ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        unused_addr;

  assign opcode = i_memory_inst[6:0];
  assign funct3 = i_memory_inst[14:12];

  // Branch/jump decision; only a valid instruction can redirect.
  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BRANCH: begin
        case (funct3)
          3'b000:         taken = i_memory_br_equal;
          3'b001:         taken = !i_memory_br_equal;
          3'b100, 3'b110: taken = i_memory_br_less;
          3'b101, 3'b111: taken = !i_memory_br_less;
          default:        taken = 1'b0;
        endcase
      end
      OP_JAL, OP_JALR: taken = 1'b1;
      default:         taken = 1'b0;
    endcase
  end

  assign o_memory_flush        = taken & i_memory_insn_vld;
  assign o_memory_pc_target    = i_memory_alu_data & ~32'h1;
  assign o_memory_fwd_alu_data = i_memory_alu_data;

  // Alignment only matters for real memory accesses.
  assign is_half   = (i_memory_slt_sl[1:0] == 2'b01);
  assign is_word   = (i_memory_slt_sl == SZ_W);
  assign is_access = i_memory_lsu_wren | (i_memory_wb_sel == WB_LD);
  assign mis_now   = i_memory_insn_vld & is_access &
                     ((is_half & i_memory_alu_data[0]) |
                      (is_word & (i_memory_alu_data[1:0] != 2'b00)));

  assign store_we = i_memory_lsu_wren & i_memory_insn_vld & !mis_now & !i_memory_reset;

  // Lane enables and replicated store data by access size.
  always_comb begin
    be    = 4'b1111;
    wdata = i_memory_rs2_data;
    case (i_memory_slt_sl[1:0])
      2'b00: begin
        be    = 4'b0001 << i_memory_alu_data[1:0];
        wdata = {4{i_memory_rs2_data[7:0]}};
      end
      2'b01: begin
        be    = i_memory_alu_data[1] ? 4'b1100 : 4'b0011;
        wdata = {2{i_memory_rs2_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign unused_addr = ^i_memory_alu_data[31:ADDR_W+2];

  memory_dmem #(.DMEM_WORDS(DMEM_WORDS), .ADDR_W(ADDR_W)) u_dmem (
    .i_memory_clk (i_memory_clk),
    .we           (store_we),
    .be           (be),
    .idx          (i_memory_alu_data[ADDR_W+1:2]),
    .wdata        (wdata),
    .rdata        (rdata)
  );

  // MEM/WB register; bubbles never write rd and carry a NOP.
  always_ff @(posedge i_memory_clk) begin
    if (i_memory_reset) begin
      alu_q                <= '0;
      slt_q                <= '0;
      wb_sel_q             <= '0;
      o_memory_pc_wb       <= '0;
      o_memory_inst_wb     <= NOP_INST;
      o_memory_rd_wren_wb  <= 1'b0;
      o_memory_insn_vld_wb <= 1'b0;
      o_memory_ctrl_wb     <= 1'b0;
      o_memory_misaligned  <= 1'b0;
    end else begin
      alu_q                <= i_memory_alu_data;
      slt_q                <= i_memory_slt_sl;
      wb_sel_q             <= i_memory_wb_sel;
      o_memory_pc_wb       <= i_memory_pc;
      o_memory_inst_wb     <= i_memory_insn_vld ? i_memory_inst : NOP_INST;
      o_memory_rd_wren_wb  <= i_memory_rd_wren & i_memory_insn_vld;
      o_memory_insn_vld_wb <= i_memory_insn_vld;
      o_memory_ctrl_wb     <= i_memory_ctrl;
      o_memory_misaligned  <= mis_now;
    end
  end

  // Load extraction from the registered word using registered offset/size.
  always_comb begin
    ld_byte = rdata[8*alu_q[1:0] +: 8];
    ld_half = alu_q[1] ? rdata[31:16] : rdata[15:0];
    case (slt_q)
      SZ_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      SZ_BU:   ld_data = {24'h0, ld_byte};
      SZ_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      SZ_HU:   ld_data = {16'h0, ld_half};
      default: ld_data = rdata;
    endcase
    if (o_memory_misaligned) ld_data = '0;
  end

  // Write-back select.
  always_comb begin
    case (wb_sel_q)
      WB_LD:   o_memory_wb_data = ld_data;
      WB_PC4:  o_memory_wb_data = o_memory_pc_wb + 32'd4;
      default: o_memory_wb_data = alu_q;
    endcase
  end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed self-checking bench for memory_cycle.
module tb_memory_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, inst, alu, rs2;
  logic        vld, ctrl, beq, blt, wren, rdw;
  logic [2:0]  slt;
  logic [1:0]  wbs;
  logic        flush, mis, rdw_wb, vld_wb, ctrl_wb;
  logic [31:0] target, fwd, wb_data, inst_wb, pc_wb;

  int tests = 0;
  int fails = 0;

  memory_cycle dut (
    .i_memory_clk          (clk),
    .i_memory_reset        (rst),
    .i_memory_pc           (pc),
    .i_memory_inst         (inst),
    .i_memory_insn_vld     (vld),
    .i_memory_ctrl         (ctrl),
    .i_memory_alu_data     (alu),
    .i_memory_rs2_data     (rs2),
    .i_memory_br_equal     (beq),
    .i_memory_br_less      (blt),
    .i_memory_lsu_wren     (wren),
    .i_memory_slt_sl       (slt),
    .i_memory_wb_sel       (wbs),
    .i_memory_rd_wren      (rdw),
    .o_memory_flush        (flush),
    .o_memory_pc_target    (target),
    .o_memory_fwd_alu_data (fwd),
    .o_memory_misaligned   (mis),
    .o_memory_wb_data      (wb_data),
    .o_memory_rd_wren_wb   (rdw_wb),
    .o_memory_inst_wb      (inst_wb),
    .o_memory_pc_wb        (pc_wb),
    .o_memory_insn_vld_wb  (vld_wb),
    .o_memory_ctrl_wb      (ctrl_wb)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic we, input logic [1:0] ws,
                       input logic rw, input logic v);
    inst = {17'h0, f3, 5'h0, op};
    slt  = f3;
    alu  = a;
    rs2  = d;
    wren = we;
    wbs  = ws;
    rdw  = rw;
    vld  = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(7'b0010011, 3'b000, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0);
    step();
    tests++; if (inst_wb !== 32'h13) begin fails++; $display("FAIL reset_inst got %h want 00000013", inst_wb); end
    tests++; if ({pc_wb, wb_data} !== 64'h0) begin fails++; $display("FAIL reset_pc_wb got %h/%h want 0", pc_wb, wb_data); end
    tests++; if ({rdw_wb, vld_wb, ctrl_wb, mis} !== 4'b0) begin fails++; $display("FAIL reset_flags got %b want 0000", {rdw_wb, vld_wb, ctrl_wb, mis}); end
    rst = 1'b0;
  endtask

  task automatic test_word();
    drive(7'b0100011, 3'b010, 32'h40, 32'hDEADBEEF, 1'b1, 2'b00, 1'b0, 1'b1);
    step();
    drive(7'b0000011, 3'b010, 32'h40, 32'h0, 1'b0, 2'b01, 1'b1, 1'b1);
    step();
    tests++; if (wb_data !== 32'hDEADBEEF) begin fails++; $display("FAIL lw got %h want deadbeef", wb_data); end
    tests++; if (rdw_wb !== 1'b1 || mis !== 1'b0) begin fails++; $display("FAIL lw_flags got %b%b want 10", rdw_wb, mis); end
  endtask

  task automatic test_byte();
    drive(7'b0100011, 3'b000, 32'h41, 32'h12345680, 1'b1, 2'b00, 1'b0, 1'b1);
    step();
    drive(7'b0000011, 3'b000, 32'h41, 32'h0, 1'b0, 2'b01, 1'b1, 1'b1);
    step();
    tests++; if (wb_data !== 32'hFFFFFF80) begin fails++; $display("FAIL lb got %h want ffffff80", wb_data); end
    drive(7'b0000011, 3'b100, 32'h41, 32'h0, 1'b0, 2'b01, 1'b1, 1'b1);
    step();
    tests++; if (wb_data !== 32'h00000080) begin fails++; $display("FAIL lbu got %h want 00000080", wb_data); end
    drive(7'b0000011, 3'b010, 32'h40, 32'h0, 1'b0, 2'b01, 1'b1, 1'b1);
    step();
    tests++; if (wb_data !== 32'hDEAD80EF) begin fails++; $display("FAIL lw_after_sb got %h want dead80ef", wb_data); end
    drive(7'b0000011, 3'b101, 32'h42, 32'h0, 1'b0, 2'b01, 1'b1, 1'b1);
    step();
    tests++; if (wb_data !== 32'h0000DEAD) begin fails++; $display("FAIL lhu got %h want 0000dead", wb_data); end
  endtask

  task automatic test_branch();
    beq = 1'b1; blt = 1'b1;
    drive(7'b1100011, 3'b000, 32'h100, 32'h0, 1'b0, 2'b00, 1'b0, 1'b1);
    #1;
    tests++; if (flush !== 1'b1 || target !== 32'h100 || fwd !== 32'h100) begin fails++; $display("FAIL beq got %b %h %h want 1 100 100", flush, target, fwd); end
    drive(7'b1100011, 3'b001, 32'h100, 32'h0, 1'b0, 2'b00, 1'b0, 1'b1);
    #1;
    tests++; if (flush !== 1'b0) begin fails++; $display("FAIL bne got %b want 0", flush); end
    drive(7'b1100011, 3'b000, 32'h100, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0);
    #1;
    tests++; if (flush !== 1'b0) begin fails++; $display("FAIL beq_bubble got %b want 0", flush); end
    drive(7'b1100011, 3'b100, 32'h100, 32'h0, 1'b0, 2'b00, 1'b0, 1'b1);
    #1;
    tests++; if (flush !== 1'b1) begin fails++; $display("FAIL blt got %b want 1", flush); end
    drive(7'b1100011, 3'b111, 32'h100, 32'h0, 1'b0, 2'b00, 1'b0, 1'b1);
    #1;
    tests++; if (flush !== 1'b0) begin fails++; $display("FAIL bgeu got %b want 0", flush); end
    drive(7'b1100011, 3'b010, 32'h100, 32'h0, 1'b0, 2'b00, 1'b0, 1'b1);
    #1;
    tests++; if (flush !== 1'b0) begin fails++; $display("FAIL br_f3_010 got %b want 0", flush); end
    beq = 1'b0; blt = 1'b0;
  endtask

  task automatic test_jalr();
    pc = 32'h50; ctrl = 1'b1;
    drive(7'b1100111, 3'b000, 32'h203, 32'h0, 1'b0, 2'b10, 1'b1, 1'b1);
    #1;
    tests++; if (flush !== 1'b1 || target !== 32'h202) begin fails++; $display("FAIL jalr_redirect got %b %h want 1 202", flush, target); end
    step();
    tests++; if (wb_data !== 32'h54 || rdw_wb !== 1'b1) begin fails++; $display("FAIL jalr_wb got %h %b want 54 1", wb_data, rdw_wb); end
    tests++; if (pc_wb !== 32'h50 || ctrl_wb !== 1'b1 || inst_wb !== 32'h00000067) begin fails++; $display("FAIL jalr_regs got %h %b %h want 50 1 00000067", pc_wb, ctrl_wb, inst_wb); end
    pc = 32'h0; ctrl = 1'b0;
  endtask

  task automatic test_misaligned();
    drive(7'b0100011, 3'b010, 32'h42, 32'h12345678, 1'b1, 2'b00, 1'b0, 1'b1);
    step();
    tests++; if (mis !== 1'b1) begin fails++; $display("FAIL sw_mis got %b want 1", mis); end
    drive(7'b0000011, 3'b010, 32'h40, 32'h0, 1'b0, 2'b01, 1'b1, 1'b1);
    step();
    tests++; if (wb_data !== 32'hDEAD80EF || mis !== 1'b0) begin fails++; $display("FAIL sw_mis_nowrite got %h %b want dead80ef 0", wb_data, mis); end
    drive(7'b0000011, 3'b001, 32'h43, 32'h0, 1'b0, 2'b01, 1'b1, 1'b1);
    step();
    tests++; if (wb_data !== 32'h0 || mis !== 1'b1) begin fails++; $display("FAIL lh_mis got %h %b want 0 1", wb_data, mis); end
  endtask

  task automatic test_bubble();
    drive(7'b0100011, 3'b010, 32'h42, 32'h0, 1'b1, 2'b01, 1'b1, 1'b0);
    step();
    tests++; if (rdw_wb !== 1'b0 || inst_wb !== 32'h13 || vld_wb !== 1'b0 || mis !== 1'b0) begin fails++; $display("FAIL bubble got %b %h %b %b want 0 00000013 0 0", rdw_wb, inst_wb, vld_wb, mis); end
  endtask

  task automatic test_wrap();
    drive(7'b0100011, 3'b010, 32'h1040, 32'hCAFEF00D, 1'b1, 2'b00, 1'b0, 1'b1);
    step();
    drive(7'b0000011, 3'b010, 32'h40, 32'h0, 1'b0, 2'b01, 1'b1, 1'b1);
    step();
    tests++; if (wb_data !== 32'hCAFEF00D) begin fails++; $display("FAIL wrap got %h want cafef00d", wb_data); end
  endtask

  task automatic test_reset_store();
    drive(7'b0100011, 3'b010, 32'h80, 32'h11111111, 1'b1, 2'b00, 1'b0, 1'b1);
    step();
    rst = 1'b1;
    drive(7'b0100011, 3'b010, 32'h80, 32'h22222222, 1'b1, 2'b00, 1'b1, 1'b1);
    step();
    tests++; if (inst_wb !== 32'h13 || rdw_wb !== 1'b0 || vld_wb !== 1'b0 || wb_data !== 32'h0) begin fails++; $display("FAIL reset_mid got %h %b %b %h want 00000013 0 0 0", inst_wb, rdw_wb, vld_wb, wb_data); end
    rst = 1'b0;
    drive(7'b0000011, 3'b010, 32'h80, 32'h0, 1'b0, 2'b01, 1'b1, 1'b1);
    step();
    tests++; if (wb_data !== 32'h11111111) begin fails++; $display("FAIL reset_blocks_store got %h want 11111111", wb_data); end
  endtask

  initial begin
    rst = 1'b1; pc = 32'h0; ctrl = 1'b0; beq = 1'b0; blt = 1'b0;
    test_reset();
    test_word();
    test_byte();
    test_branch();
    test_jalr();
    test_misaligned();
    test_bubble();
    test_wrap();
    test_reset_store();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
